// File: rtl/telemetry_scheduler.sv
// Round-robin telemetry scheduler: sends changed 16-bit telemetry slots as
// request/ack/done frames with timeout, bounded retry and an inter-frame gap.
module telemetry_scheduler #(
  parameter int TIMEOUT_CYC = 2500000,
  parameter int MAX_RETRY   = 3,
  parameter int GAP_CYC     = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         swiptAlive,
  input  logic [1:0]   prog,        // operating program; scheduler runs only at 2'b11
  input  logic [143:0] fields,
  output logic         tx_req,
  output logic [1:0]   tx_mode,
  output logic [1:0]   tx_type,
  output logic [15:0]  tx_data,
  input  logic         tx_ack,
  input  logic         tx_done,
  input  logic         tx_ok,
  output logic         busy,
  output logic         sent_pulse,
  output logic         drop_pulse,
  output logic [7:0]   err_count
);
  localparam int NS = 9;
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
  localparam logic [RW-1:0] MAX_R  = RW'(MAX_RETRY);
  localparam logic [23:0]   TMO_LD = 24'(TIMEOUT_CYC);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYC);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [15:0]     shadow [NS];
  logic [15:0]     field_w [NS];
  logic [NS-1:0]   pending, pend_eff;
  logic [3:0]      last_grant, slot, pick;
  logic [4:0]      idx;
  logic [RW-1:0]   retry;
  logic [23:0]     timer;
  logic [GW-1:0]   gap_cnt;
  logic            found, en, in_xfer, expired, grant;
  logic            done_evt, ok_evt, fail_evt, retry_evt, drop_evt;

  function automatic logic [3:0] slot_hdr(input logic [3:0] s);
    logic [3:0] h;
    case (s)
      4'd0, 4'd1, 4'd2, 4'd3: h = {2'b01, s[1:0]};
      4'd4:    h = 4'b1000;
      4'd5:    h = 4'b1001;
      4'd6:    h = 4'b1100;
      4'd7:    h = 4'b1101;
      4'd8:    h = 4'b1110;
      default: h = 4'b0000;
    endcase
    return h;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A slot is pending if its sticky bit is set or it differs from its shadow right now.
  always_comb begin
    en = swiptAlive && (prog == 2'b11);
    for (int i = 0; i < NS; i++) begin
      field_w[i]  = fields[16*i +: 16];
      pend_eff[i] = pending[i] || (field_w[i] != shadow[i]);
    end
  end

  // Round-robin search starts one past the last granted slot and wraps at 9.
  always_comb begin
    pick  = 4'd0;
    found = 1'b0;
    idx   = 5'd0;
    for (int k = 1; k <= NS; k++) begin
      idx = {1'b0, last_grant} + 5'(k);
      if (idx >= 5'(NS)) idx = idx - 5'(NS);
      if (!found && pend_eff[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
  end

  // An ack+done pair in REQ resolves as a completed transfer in that cycle.
  always_comb begin
    in_xfer   = en && (state == S_REQ || state == S_WAIT);
    expired   = (timer <= 24'd1);
    done_evt  = in_xfer && tx_done && (state == S_WAIT || tx_ack);
    ok_evt    = done_evt && tx_ok;
    fail_evt  = (done_evt && !tx_ok) || (in_xfer && !done_evt && expired);
    retry_evt = fail_evt && (retry < MAX_R);
    drop_evt  = fail_evt && !(retry < MAX_R);
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant     = 1'b1;
            state_nxt = S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          if (ok_evt || drop_evt)             state_nxt = S_GAP;
          else if (retry_evt)                 state_nxt = S_REQ;
          else if (state == S_REQ && tx_ack)  state_nxt = S_WAIT;
        end
        S_GAP: begin
          if (gap_cnt <= GW'(1)) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign tx_req = (state == S_REQ);
  assign busy   = (state == S_REQ) || (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_mode    <= 2'b00;
      tx_type    <= 2'b00;
      tx_data    <= 16'h0000;
      sent_pulse <= 1'b0;
      drop_pulse <= 1'b0;
      err_count  <= 8'h00;
      pending    <= '1;
      last_grant <= 4'd8;
      slot       <= 4'd0;
      retry      <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      for (int i = 0; i < NS; i++) shadow[i] <= 16'h0000;
    end else begin
      sent_pulse <= ok_evt;
      drop_pulse <= drop_evt;
      pending    <= pend_eff;

      if (grant) begin
        slot               <= pick;
        last_grant         <= pick;
        tx_data            <= field_w[pick];
        {tx_mode, tx_type} <= slot_hdr(pick);
      end

      if (ok_evt) begin
        shadow[slot]  <= tx_data;
        pending[slot] <= (field_w[slot] != tx_data);
      end

      if (fail_evt) err_count <= sat_inc8(err_count);

      if (!en || ok_evt || drop_evt) retry <= '0;
      else if (retry_evt)            retry <= retry + 1'b1;

      if (!en)                                timer <= '0;
      else if (grant || retry_evt)            timer <= TMO_LD;
      else if (in_xfer && timer != 24'd0)     timer <= timer - 24'd1;

      if (!en)                                gap_cnt <= '0;
      else if (ok_evt || drop_evt)            gap_cnt <= GAP_LD;
      else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_telemetry_scheduler.sv
// Bench for telemetry_scheduler: directed scenarios plus randomized frames
// checked against a slot-level reference model (pending/shadow/round-robin).
module tb_telemetry_scheduler;
  localparam int TMO  = 100;
  localparam int MAXR = 3;
  localparam int GAP  = 20;
  localparam logic [3:0] HDR [9] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE};

  logic         clk = 1'b0;
  logic         rst;
  logic         swiptAlive;
  logic [1:0]   prog;
  logic [143:0] fields;
  logic         tx_req;
  logic [1:0]   tx_mode, tx_type;
  logic [15:0]  tx_data;
  logic         tx_ack, tx_done, tx_ok;
  logic         busy, sent_pulse, drop_pulse;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] fld [9];
  logic [15:0] shadow_m [9];
  bit          pend_m [9];
  int          last_m, cur, retry_m, err_m;
  logic [15:0] cur_data;

  telemetry_scheduler #(.TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .swiptAlive(swiptAlive), .prog(prog), .fields(fields),
    .tx_req(tx_req), .tx_mode(tx_mode), .tx_type(tx_type), .tx_data(tx_data),
    .tx_ack(tx_ack), .tx_done(tx_done), .tx_ok(tx_ok), .busy(busy),
    .sent_pulse(sent_pulse), .drop_pulse(drop_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_field(input int i, input logic [15:0] v);
    fld[i] = v;
    fields[16*i +: 16] = v;
    if (v != shadow_m[i]) pend_m[i] = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      shadow_m[i] = 16'h0000;
      pend_m[i]   = 1'b1;
    end
    last_m  = 8;
    err_m   = 0;
    retry_m = 0;
  endtask

  function automatic bit pend_any();
    for (int i = 0; i < 9; i++) if (pend_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= 9; k++) if (pend_m[(last_m + k) % 9]) return (last_m + k) % 9;
    return -1;
  endfunction

  task automatic expect_grant();
    int s;
    int n;
    s = rr_pick();
    n = 0;
    while (tx_req !== 1'b1 && n < GAP + 10) begin
      step();
      n++;
    end
    chk("grant_seen", 32'(tx_req), 32'd1);
    if (s < 0) s = 0;
    cur      = s;
    cur_data = fld[s];
    last_m   = s;
    chk("grant_hdr", 32'({tx_mode, tx_type}), 32'(HDR[s]));
    chk("grant_data", 32'(tx_data), 32'(fld[s]));
    chk("grant_busy", 32'(busy), 32'd1);
  endtask

  // Starts in the first REQ cycle of an attempt; returns just after its outcome edge.
  task automatic attempt(input bit ok, input bit tmo, input bit same, input int chg_slot,
                         input logic [15:0] chg_val, input int ack_dly, output bit fin);
    int ad;
    int dd;
    int used;
    ad   = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
    used = ad + 1;
    fin  = 1'b0;
    for (int i = 0; i < ad; i++) begin
      chk("req_hold", 32'(tx_req), 32'd1);
      chk("data_hold", 32'(tx_data), 32'(cur_data));
      step();
    end
    if (same && !tmo) begin
      tx_ack = 1'b1; tx_done = 1'b1; tx_ok = ok;
      step();
      tx_ack = 1'b0; tx_done = 1'b0; tx_ok = 1'b0;
    end else begin
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
      chk("wait_req_low", 32'(tx_req), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      if (chg_slot >= 0) begin
        set_field(chg_slot, chg_val);
        step();
        used++;
        chk("data_frozen", 32'(tx_data), 32'(cur_data));
      end
      if (tmo) begin
        repeat (TMO - used - 1) step();
        chk("pre_timeout_busy", 32'(busy), 32'd1);
        chk("pre_timeout_req", 32'(tx_req), 32'd0);
        step();
      end else begin
        dd = $urandom_range(0, 3);
        repeat (dd) step();
        tx_done = 1'b1; tx_ok = ok;
        step();
        tx_done = 1'b0; tx_ok = 1'b0;
      end
    end
    if (ok && !tmo) begin
      shadow_m[cur] = cur_data;
      pend_m[cur]   = (fld[cur] != cur_data);
      retry_m       = 0;
      chk("sent_pulse", 32'(sent_pulse), 32'd1);
      chk("sent_nodrop", 32'(drop_pulse), 32'd0);
      chk("sent_busy", 32'(busy), 32'd0);
      chk("sent_err", 32'(err_count), 32'(err_m));
      fin = 1'b1;
    end else begin
      err_m = (err_m >= 255) ? 255 : err_m + 1;
      chk("fail_err", 32'(err_count), 32'(err_m));
      chk("fail_nosent", 32'(sent_pulse), 32'd0);
      if (retry_m < MAXR) begin
        retry_m++;
        chk("retry_req", 32'(tx_req), 32'd1);
        chk("retry_data", 32'(tx_data), 32'(cur_data));
        chk("retry_nodrop", 32'(drop_pulse), 32'd0);
      end else begin
        retry_m = 0;
        chk("drop_pulse", 32'(drop_pulse), 32'd1);
        chk("drop_busy", 32'(busy), 32'd0);
        fin = 1'b1;
      end
    end
  endtask

  task automatic run_attempts(input int nfail, input bit tmo, input bit same,
                              input int chg_slot, input logic [15:0] chg_val);
    bit fin;
    fin = 1'b0;
    for (int a = 0; a <= MAXR && !fin; a++)
      attempt(a >= nfail, tmo && (a < nfail), same && (a >= nfail),
              (a == 0) ? chg_slot : -1, chg_val, -1, fin);
    step();
    chk("pulse_width_sent", 32'(sent_pulse), 32'd0);
    chk("pulse_width_drop", 32'(drop_pulse), 32'd0);
  endtask

  task automatic frame(input int nfail, input bit tmo, input bit same,
                       input int chg_slot, input logic [15:0] chg_val);
    expect_grant();
    run_attempts(nfail, tmo, same, chg_slot, chg_val);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pend_any() && n < 12) begin
      frame(0, 1'b0, 1'($urandom_range(0, 1)), -1, 16'h0);
      n++;
    end
  endtask

  initial begin
    bit fin;
    int nchg, base, r, nf;
    bit tm, sm;

    rst = 1'b1; swiptAlive = 1'b0; prog = 2'b00; fields = '0;
    tx_ack = 1'b0; tx_done = 1'b0; tx_ok = 1'b0;
    for (int i = 0; i < 9; i++) fld[i] = 16'h0000;
    model_reset();
    set_field(0, 16'h1234);
    step(); step();
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_tx_mode", 32'(tx_mode), 32'd0);
    chk("rst_tx_type", 32'(tx_type), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sent", 32'(sent_pulse), 32'd0);
    chk("rst_drop", 32'(drop_pulse), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    rst = 1'b0; swiptAlive = 1'b1; prog = 2'b11;

    // First frame: slot 0 after reset, ack after 5 cycles, exact gap length.
    expect_grant();
    chk("first_slot_data", 32'(tx_data), 32'h1234);
    attempt(1'b1, 1'b0, 1'b0, -1, 16'h0, 5, fin);
    step();
    chk("pulse_clear", 32'(sent_pulse), 32'd0);
    tx_ack = 1'b1; tx_done = 1'b1; tx_ok = 1'b1;
    step();
    tx_ack = 1'b0; tx_done = 1'b0; tx_ok = 1'b0;
    chk("stray_done_ignored", 32'(sent_pulse), 32'd0);
    repeat (GAP - 2) step();
    chk("gap_hold", 32'(tx_req), 32'd0);
    step();
    chk("gap_release", 32'(tx_req), 32'd1);
    expect_grant();
    run_attempts(0, 1'b0, 1'b0, -1, 16'h0);

    // Slot 7 dropped after 4 failed replies; re-granted only after slots 8 and 0.
    set_field(7, 16'hABCD);
    repeat (5) frame(0, 1'b0, 1'($urandom_range(0, 1)), -1, 16'h0);
    set_field(0, 16'h0F0F);
    frame(4, 1'b0, 1'b0, -1, 16'h0);
    chk("err_after_drop", 32'(err_count), 32'd4);
    repeat (3) frame(0, 1'b0, 1'b0, -1, 16'h0);
    drain();

    // Timeouts with no tx_done.
    set_field(3, 16'h3C3C);
    frame(4, 1'b1, 1'b0, -1, 16'h0);
    chk("err_after_timeouts", 32'(err_count), 32'd8);
    frame(0, 1'b0, 1'b0, -1, 16'h0);

    // Field change while in WAIT: old value sent, new value sent next time.
    set_field(2, 16'h0005);
    frame(0, 1'b0, 1'b0, 2, 16'h0009);
    expect_grant();
    chk("resend_new_value", 32'(tx_data), 32'h0009);
    run_attempts(0, 1'b0, 1'b0, -1, 16'h0);

    // Ack and done together.
    set_field(5, 16'h5A5A);
    frame(0, 1'b0, 1'b1, -1, 16'h0);

    // Disable during WAIT after one failed attempt.
    drain();
    set_field(6, 16'h6A6A);
    expect_grant();
    attempt(1'b0, 1'b0, 1'b0, -1, 16'h0, -1, fin);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    prog = 2'b10;
    step();
    retry_m = 0;
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_req", 32'(tx_req), 32'd0);
    chk("dis_sent", 32'(sent_pulse), 32'd0);
    chk("dis_drop", 32'(drop_pulse), 32'd0);
    chk("dis_err", 32'(err_count), 32'(err_m));
    repeat (3) begin
      step();
      chk("dis_idle_req", 32'(tx_req), 32'd0);
    end
    prog = 2'b11;
    frame(4, 1'b0, 1'b0, -1, 16'h0);
    frame(0, 1'b0, 1'b0, -1, 16'h0);

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      nchg = $urandom_range(0, 3);
      base = $urandom_range(0, 8);
      for (int c = 0; c < nchg; c++) set_field((base + c) % 9, 16'($urandom));
      if (pend_any()) begin
        r  = $urandom_range(0, 9);
        nf = (r < 6) ? 0 : ((r < 8) ? int'($urandom_range(1, 3)) : 4);
        tm = (nf > 0) && ($urandom_range(0, 4) == 0);
        sm = 1'($urandom_range(0, 1));
        frame(nf, tm, sm, -1, 16'h0);
      end
    end

    // Reset in the middle of a request.
    drain();
    set_field(4, 16'h4D4D);
    expect_grant();
    rst = 1'b1;
    step();
    chk("midrst_req", 32'(tx_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err_count), 32'd0);
    chk("midrst_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    model_reset();
    expect_grant();
    run_attempts(0, 1'b0, 1'b0, -1, 16'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
